// File: rtl/pipe_stage_buf.sv
// Parametrised inter-stage pipeline register: valid/ready handshake, flush, bubble
// insertion, optional 2-entry skid for a registered in_ready, saturating stall counter.
module pipe_stage_buf #(
    parameter int unsigned  DATA_W     = 64,
    parameter int unsigned  SKID       = 1,
    parameter logic [511:0] BUBBLE_VAL = 512'h0000_0000_0000_0013,
    parameter int unsigned  CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr
);

    localparam logic [DATA_W-1:0] BUBBLE  = BUBBLE_VAL[DATA_W-1:0];
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    logic              rdy_en_p0;
    logic              main_vld_p0;
    logic              skid_vld_p0;
    logic [DATA_W-1:0] main_data_p0;
    logic [DATA_W-1:0] skid_data_p0;
    logic              push;
    logic              pop;

    // rdy_en_p0 holds in_ready low while in reset and for the edge it is released on
    assign in_ready  = rdy_en_p0 & ((SKID != 0) ? ~skid_vld_p0 : (out_ready | ~main_vld_p0));
    assign push      = in_valid & in_ready;
    assign pop       = main_vld_p0 & out_ready;
    assign out_valid = main_vld_p0;
    assign out_data  = main_vld_p0 ? main_data_p0 : BUBBLE;

    // ---- stage p0: main / skid storage ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en_p0    <= 1'b0;
            main_vld_p0  <= 1'b0;
            skid_vld_p0  <= 1'b0;
            main_data_p0 <= BUBBLE;
            skid_data_p0 <= BUBBLE;
        end else begin
            rdy_en_p0 <= 1'b1;
            if (flush) begin
                main_vld_p0  <= 1'b0;
                skid_vld_p0  <= 1'b0;
                main_data_p0 <= BUBBLE;
                skid_data_p0 <= BUBBLE;
            end else if (SKID != 0) begin
                if (pop && skid_vld_p0) begin
                    // in_ready is low here, so no push competes with the refill
                    main_data_p0 <= skid_data_p0;
                    skid_vld_p0  <= 1'b0;
                end else if (push && (!main_vld_p0 || pop)) begin
                    main_data_p0 <= in_data;
                    main_vld_p0  <= 1'b1;
                end else if (push) begin
                    skid_data_p0 <= in_data;
                    skid_vld_p0  <= 1'b1;
                end else if (pop) begin
                    main_vld_p0 <= 1'b0;
                end
            end else begin
                if (push) begin
                    main_data_p0 <= in_data;
                    main_vld_p0  <= 1'b1;
                end else if (pop) begin
                    main_vld_p0 <= 1'b0;
                end
            end
        end
    end

    // ---- stall counter: clear beats increment, flush leaves it alone ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall_clr) begin
            stall_cnt <= '0;
        end else if (main_vld_p0 && !out_ready) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: skid, non-skid and 4-bit-counter instances share stimulus and
// are compared against bounded-FIFO reference models plus directed scenario checks.
module tb_pipe_stage_buf;

    localparam logic [63:0] BUB = 64'h13;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] in_data;
    logic        out_ready;
    logic        flush;
    logic        stall_clr;

    logic        rdy_s, vld_s, rdy_n, vld_n, rdy_c, vld_c;
    logic [63:0] data_s, data_n, data_c;
    logic [15:0] cnt_s_o, cnt_n_o;
    logic [3:0]  cnt_c_o;

    int vectors;
    int miscompares;

    // reference model: the stage is a FIFO of depth 2 (skid) or 1 (no skid)
    logic [63:0] q_s[$];
    logic [63:0] q_n[$];
    bit          en;
    int          m_cnt_s, m_cnt_n, m_cnt_c;

    pipe_stage_buf #(.DATA_W(64), .SKID(1), .CNT_W(16)) u_skid (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_s), .in_data(in_data),
        .out_valid(vld_s), .out_ready(out_ready), .out_data(data_s), .flush(flush),
        .stall_cnt(cnt_s_o), .stall_clr(stall_clr));

    pipe_stage_buf #(.DATA_W(64), .SKID(0), .CNT_W(16)) u_noskid (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_n), .in_data(in_data),
        .out_valid(vld_n), .out_ready(out_ready), .out_data(data_n), .flush(flush),
        .stall_cnt(cnt_n_o), .stall_clr(stall_clr));

    pipe_stage_buf #(.DATA_W(64), .SKID(1), .CNT_W(4)) u_cnt4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_c), .in_data(in_data),
        .out_valid(vld_c), .out_ready(out_ready), .out_data(data_c), .flush(flush),
        .stall_cnt(cnt_c_o), .stall_clr(stall_clr));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] front_s();
        front_s = (q_s.size() > 0) ? q_s[0] : BUB;
    endfunction

    function automatic logic [63:0] front_n();
        front_n = (q_n.size() > 0) ? q_n[0] : BUB;
    endfunction

    function automatic bit exp_rdy_s();
        exp_rdy_s = en && (q_s.size() < 2);
    endfunction

    function automatic bit exp_rdy_n();
        exp_rdy_n = en && (q_n.size() == 0 || out_ready);
    endfunction

    function automatic void model_reset();
        q_s.delete();
        q_n.delete();
        en      = 1'b0;
        m_cnt_s = 0;
        m_cnt_n = 0;
        m_cnt_c = 0;
    endfunction

    // one clock edge: advance the models from the inputs held across that edge
    task automatic tick();
        bit ps, pp, pn, qn, st_s, st_n;
        ps   = in_valid && exp_rdy_s();
        pp   = (q_s.size() > 0) && out_ready;
        pn   = in_valid && exp_rdy_n();
        qn   = (q_n.size() > 0) && out_ready;
        st_s = (q_s.size() > 0) && !out_ready;
        st_n = (q_n.size() > 0) && !out_ready;
        @(posedge clk);
        if (rst_n) begin
            if (flush) begin
                q_s.delete();
                q_n.delete();
            end else begin
                if (pp) void'(q_s.pop_front());
                if (ps) q_s.push_back(in_data);
                if (qn) void'(q_n.pop_front());
                if (pn) q_n.push_back(in_data);
            end
            if (stall_clr) begin
                m_cnt_s = 0; m_cnt_n = 0; m_cnt_c = 0;
            end else begin
                if (st_s && m_cnt_s < 65535) m_cnt_s++;
                if (st_s && m_cnt_c < 15)    m_cnt_c++;
                if (st_n && m_cnt_n < 65535) m_cnt_n++;
            end
            en = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_data   = 'x;
        out_ready = 1'b0;
        flush     = 1'b0;
        stall_clr = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        vectors++; if (vld_s !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", vld_s); end
        vectors++; if (data_s !== BUB) begin miscompares++; $display("FAIL reset_out_data: got %h expected %h", data_s, BUB); end
        vectors++; if (rdy_s !== 1'b0 || rdy_n !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b/%b expected 0/0", rdy_s, rdy_n); end
        vectors++; if (cnt_s_o !== 16'd0) begin miscompares++; $display("FAIL reset_stall_cnt: got %0d expected 0", cnt_s_o); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++; if (rdy_s !== 1'b0) begin miscompares++; $display("FAIL release_in_ready_early: got %b expected 0", rdy_s); end
        tick();
        #1;
        vectors++; if (rdy_s !== 1'b1 || rdy_n !== 1'b1) begin miscompares++; $display("FAIL release_in_ready: got %b/%b expected 1/1", rdy_s, rdy_n); end
        vectors++; if (vld_s !== 1'b0 || data_s !== BUB) begin miscompares++; $display("FAIL release_empty: got %b/%h expected 0/%h", vld_s, data_s, BUB); end
    endtask

    task automatic test_stream();
        logic [63:0] e;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = 64'h100 + 64'(4 * k);
            #1;
            if (k > 0) begin
                e = 64'h100 + 64'(4 * (k - 1));
                vectors++; if (vld_s !== 1'b1 || data_s !== e) begin miscompares++; $display("FAIL stream_skid[%0d]: got %b/%h expected 1/%h", k, vld_s, data_s, e); end
                vectors++; if (vld_n !== 1'b1 || data_n !== e) begin miscompares++; $display("FAIL stream_noskid[%0d]: got %b/%h expected 1/%h", k, vld_n, data_n, e); end
            end
            tick();
        end
        in_valid = 1'b0;
        in_data  = 'x;
        #1;
        vectors++; if (vld_s !== 1'b1 || data_s !== 64'h108) begin miscompares++; $display("FAIL stream_last: got %b/%h expected 1/108", vld_s, data_s); end
        tick();
        #1;
        vectors++; if (vld_s !== 1'b0 || data_s !== BUB) begin miscompares++; $display("FAIL stream_drained: got %b/%h expected 0/%h", vld_s, data_s, BUB); end
    endtask

    task automatic test_backpressure();
        in_valid  = 1'b1;
        in_data   = 64'h200;
        out_ready = 1'b1;
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        out_ready = 1'b0;
        in_data   = 64'h204;
        #1;
        vectors++; if (rdy_s !== 1'b1 || data_s !== 64'h200) begin miscompares++; $display("FAIL bp_first_held: got %b/%h expected 1/200", rdy_s, data_s); end
        tick();
        in_valid = 1'b0;
        in_data  = 'x;
        #1;
        vectors++; if (rdy_s !== 1'b0 || data_s !== 64'h200 || cnt_s_o !== 16'd1) begin miscompares++; $display("FAIL bp_skid_full: got rdy=%b data=%h cnt=%0d expected 0/200/1", rdy_s, data_s, cnt_s_o); end
        tick();
        #1;
        vectors++; if (rdy_s !== 1'b0 || data_s !== 64'h200 || cnt_s_o !== 16'd2) begin miscompares++; $display("FAIL bp_stalled: got rdy=%b data=%h cnt=%0d expected 0/200/2", rdy_s, data_s, cnt_s_o); end
        out_ready = 1'b1;
        #1;
        vectors++; if (vld_s !== 1'b1 || data_s !== 64'h200) begin miscompares++; $display("FAIL bp_drain0: got %b/%h expected 1/200", vld_s, data_s); end
        tick();
        #1;
        vectors++; if (vld_s !== 1'b1 || data_s !== 64'h204 || rdy_s !== 1'b1) begin miscompares++; $display("FAIL bp_drain1: got vld=%b data=%h rdy=%b expected 1/204/1", vld_s, data_s, rdy_s); end
        tick();
        #1;
        vectors++; if (vld_s !== 1'b0 || rdy_s !== 1'b1 || cnt_s_o !== 16'd2) begin miscompares++; $display("FAIL bp_empty: got vld=%b rdy=%b cnt=%0d expected 0/1/2", vld_s, rdy_s, cnt_s_o); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h300;
        tick();
        in_data = 64'h304;
        tick();
        #1;
        vectors++; if (rdy_s !== 1'b0 || data_s !== 64'h300) begin miscompares++; $display("FAIL flush_prefill: got %b/%h expected 0/300", rdy_s, data_s); end
        in_data = 64'h308;
        flush   = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        in_data  = 'x;
        #1;
        vectors++; if (vld_s !== 1'b0 || data_s !== BUB || rdy_s !== 1'b1) begin miscompares++; $display("FAIL flush_skid: got vld=%b data=%h rdy=%b expected 0/%h/1", vld_s, data_s, rdy_s, BUB); end
        vectors++; if (vld_n !== 1'b0 || rdy_n !== 1'b1) begin miscompares++; $display("FAIL flush_noskid: got vld=%b rdy=%b expected 0/1", vld_n, rdy_n); end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 64'h30c;
        flush     = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            #1;
            vectors++; if (vld_s !== 1'b0 || vld_n !== 1'b0) begin miscompares++; $display("FAIL flush_held[%0d]: got %b/%b expected 0/0", k, vld_s, vld_n); end
        end
        flush    = 1'b0;
        in_valid = 1'b0;
        in_data  = 'x;
        tick();
    endtask

    task automatic test_noskid_toggle();
        bit          pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [63:0] nv = 64'h400;
        bit          e;
        for (int k = 0; k < 6; k++) begin
            in_valid  = 1'b1;
            in_data   = nv;
            out_ready = pat[k];
            #1;
            e = exp_rdy_n();
            vectors++; if (rdy_n !== e) begin miscompares++; $display("FAIL toggle_ready[%0d]: got %b expected %b", k, rdy_n, e); end
            vectors++; if (data_n !== front_n()) begin miscompares++; $display("FAIL toggle_data[%0d]: got %h expected %h", k, data_n, front_n()); end
            if (e) nv = nv + 64'd4;
            tick();
        end
        in_data   = nv;
        out_ready = 1'b0;
        #1;
        vectors++; if (rdy_n !== 1'b0) begin miscompares++; $display("FAIL toggle_comb_low: got %b expected 0", rdy_n); end
        out_ready = 1'b1;
        #1;
        vectors++; if (rdy_n !== 1'b1) begin miscompares++; $display("FAIL toggle_comb_high: got %b expected 1", rdy_n); end
        tick();
        in_valid = 1'b0;
        in_data  = 'x;
        #1;
        vectors++; if (vld_n !== 1'b1 || data_n !== nv) begin miscompares++; $display("FAIL toggle_last: got %b/%h expected 1/%h", vld_n, data_n, nv); end
        repeat (3) tick();
    endtask

    task automatic test_saturation();
        in_valid  = 1'b1;
        in_data   = 64'h500;
        out_ready = 1'b0;
        stall_clr = 1'b1;
        tick();
        in_valid  = 1'b0;
        in_data   = 'x;
        stall_clr = 1'b0;
        repeat (20) tick();
        #1;
        vectors++; if (cnt_c_o !== 4'd15) begin miscompares++; $display("FAIL sat_cnt4: got %0d expected 15", cnt_c_o); end
        vectors++; if (cnt_s_o !== 16'd20) begin miscompares++; $display("FAIL sat_cnt16: got %0d expected 20", cnt_s_o); end
        stall_clr = 1'b1;
        tick();
        #1;
        vectors++; if (cnt_c_o !== 4'd0 || cnt_s_o !== 16'd0) begin miscompares++; $display("FAIL sat_clear: got %0d/%0d expected 0/0", cnt_c_o, cnt_s_o); end
        stall_clr = 1'b0;
        tick();
        #1;
        vectors++; if (cnt_c_o !== 4'd1) begin miscompares++; $display("FAIL sat_resume: got %0d expected 1", cnt_c_o); end
        out_ready = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h600;
        tick();
        in_data = 64'h604;
        tick();
        in_valid = 1'b0;
        in_data  = 'x;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        vectors++; if (vld_s !== 1'b0 || data_s !== BUB || rdy_s !== 1'b0 || cnt_s_o !== 16'd0) begin miscompares++; $display("FAIL mid_reset: got vld=%b data=%h rdy=%b cnt=%0d expected 0/%h/0/0", vld_s, data_s, rdy_s, cnt_s_o, BUB); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        #1;
        vectors++; if (vld_s !== 1'b0 || rdy_s !== 1'b1 || vld_n !== 1'b0) begin miscompares++; $display("FAIL mid_reset_release: got vld=%b rdy=%b vld_n=%b expected 0/1/0", vld_s, rdy_s, vld_n); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = in_valid ? {$urandom(), $urandom()} : 'x;
            out_ready = (k < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            flush     = ($urandom_range(0, 24) == 0);
            stall_clr = ($urandom_range(0, 39) == 0);
            #1;
            vectors++; if (rdy_s !== exp_rdy_s()) begin miscompares++; $display("FAIL rnd_rdy_s[%0d]: got %b expected %b", k, rdy_s, exp_rdy_s()); end
            vectors++; if (vld_s !== (q_s.size() > 0) || data_s !== front_s()) begin miscompares++; $display("FAIL rnd_out_s[%0d]: got %b/%h expected %b/%h", k, vld_s, data_s, q_s.size() > 0, front_s()); end
            vectors++; if (cnt_s_o !== 16'(m_cnt_s)) begin miscompares++; $display("FAIL rnd_cnt_s[%0d]: got %0d expected %0d", k, cnt_s_o, m_cnt_s); end
            vectors++; if (rdy_n !== exp_rdy_n()) begin miscompares++; $display("FAIL rnd_rdy_n[%0d]: got %b expected %b", k, rdy_n, exp_rdy_n()); end
            vectors++; if (vld_n !== (q_n.size() > 0) || data_n !== front_n()) begin miscompares++; $display("FAIL rnd_out_n[%0d]: got %b/%h expected %b/%h", k, vld_n, data_n, q_n.size() > 0, front_n()); end
            vectors++; if (cnt_n_o !== 16'(m_cnt_n)) begin miscompares++; $display("FAIL rnd_cnt_n[%0d]: got %0d expected %0d", k, cnt_n_o, m_cnt_n); end
            vectors++; if (rdy_c !== exp_rdy_s() || data_c !== front_s() || cnt_c_o !== 4'(m_cnt_c)) begin miscompares++; $display("FAIL rnd_c4[%0d]: got %b/%h/%0d expected %b/%h/%0d", k, rdy_c, data_c, cnt_c_o, exp_rdy_s(), front_s(), m_cnt_c); end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        idle_inputs();
        model_reset();
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_noskid_toggle();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised inter-stage pipeline register for the 5-stage core. It is the generalised successor of the fixed per-field stage registers (if_id, id_ex, ex_mem, mem_wb).
- Carries one opaque payload word (PC, instruction and control bundle concatenated by the instantiating stage) with a valid/ready handshake, flush and bubble insertion.
- Optional 2-entry skid mode registers the upstream ready, breaking the combinational ready path across stages.
- Saturating stall counter supports pipeline performance counters.

Parameters:
- DATA_W, 64: payload width in bits (legal 1..512).
- SKID, 1: 0 = single register with combinational in_ready; 1 = main + skid register with registered in_ready.
- BUBBLE_VAL, 64'h0000_0000_0000_0013: value driven on out_data when out_valid=0. Default is the NOP encoding in the low 32 bits; it is truncated or zero-extended to DATA_W.
- CNT_W, 16: stall counter width.

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: upstream payload valid.
- in_ready, output, 1: this stage can accept a payload.
- in_data, input, DATA_W: upstream payload.
- out_valid, output, 1: payload available downstream.
- out_ready, input, 1: downstream accepts the payload.
- out_data, output, DATA_W: downstream payload (BUBBLE_VAL when out_valid=0).
- flush, input, 1: synchronous kill of all held and incoming payloads (branch/jump redirect).
- stall_cnt, output, CNT_W: count of cycles with out_valid=1 and out_ready=0.
- stall_clr, input, 1: synchronous clear of stall_cnt.

Behaviour:
- Reset (async, rst_n=0):
  - main_valid=0, skid_valid=0, stall_cnt=0, stored data regs=BUBBLE_VAL.
  - Outputs during reset: out_valid=0, out_data=BUBBLE_VAL, in_ready=0.
  - in_ready rises in the first cycle after rst_n deasserts.
- Transfer rules:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - Payload order is strictly preserved. No payload is duplicated or lost except by flush.
- SKID=0:
  - in_ready = out_ready | ~main_valid (combinational).
  - On push, main loads in_data; main_valid=1 next cycle.
  - On pop without push, main_valid=0.
  - Latency is 1 cycle.
- SKID=1:
  - in_ready = ~skid_valid (registered, no combinational path from out_ready).
  - push with main empty, or push with pop: main loads in_data.
  - push while main holds and no pop: skid loads in_data; skid_valid=1.
  - pop with skid_valid=1: skid moves to main; skid_valid=0. No push can occur that cycle, since in_ready=0.
  - Latency is 1 cycle. Sustained throughput is 1 payload per cycle when out_ready is held high.
- out_valid = main_valid. out_data = main_valid ? main_data : BUBBLE_VAL.
- Flush:
  - Highest priority. Next cycle main_valid=0 and skid_valid=0; data regs return to BUBBLE_VAL.
  - A push in the flush cycle is discarded.
  - A pop in the flush cycle still completes, because downstream sampled it that cycle.
  - Flush held for N cycles keeps the stage empty for N cycles.
  - in_ready in the cycle after flush is 1 (both modes).
- Stall counter:
  - Increments each cycle with out_valid & ~out_ready.
  - Saturates at 2^CNT_W-1 with no wrap.
  - stall_clr has priority over increment: it clears to 0 that edge.
  - Flush does not clear stall_cnt.
- Reset mid-operation: held payloads are discarded immediately (async). No partial state survives.
- in_data is X-tolerant when in_valid=0: X must never propagate to out_data while out_valid=0.

Test Plan:
- Reset with DATA_W=64, SKID=1 -> out_valid=0, out_data=0x13, stall_cnt=0. in_ready=1 one cycle after rst_n rises.
- Streaming, out_ready=1, in_valid=1, in_data=0x100,0x104,0x108 on consecutive cycles -> out_data 0x100,0x104,0x108 one cycle later each, no bubbles.
- Backpressure, SKID=1: out_ready=0 after 0x200 is pushed, then push 0x204.
  - Required: in_ready=0, skid holds 0x204, out_data stays 0x200, stall_cnt increments each cycle.
  - After out_ready=1: 0x200 then 0x204, then in_ready=1.
- Flush with both entries full (0x300 main, 0x304 skid) plus in_valid=1, in_data=0x308 -> next cycle out_valid=0, out_data=0x13, in_ready=1; 0x308 never appears.
- SKID=0 with out_ready toggling 1,0,1 under continuous input 0x400.. -> in_ready tracks out_ready|~out_valid combinationally; order preserved.
- Counter saturation, CNT_W=4, out_ready=0 for 20 cycles -> stall_cnt=15. Then stall_clr=1 -> 0 next cycle, even with the stall still ongoing.
